// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Types and constants shared by the control pipeline of the 5-stage RISC-V core.
//   ctrl_t     : decoded control bundle produced by main_control in ID
//   ALU_OP_*   : ALU operation class carried in ctrl_t.alu_op
//   OP_*       : base opcodes that main_control decodes
//   fwd_sel_e  : EX operand source select driven by the forwarding unit
package ctrl_pkg;

  // Field order is fixed by main_control: alu_op sits in the MSBs,
  // reg_write in the LSB.
  typedef struct packed {
    logic [1:0] alu_op;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_write;
  } ctrl_t;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_BR  = 2'b01;
  localparam logic [1:0] ALU_OP_R   = 2'b10;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/ctrl_pipeline_hazard_detect.sv
// hazard_detect
// Purely combinational hazard unit for the control pipeline.
//   id_valid, id_rs1, id_rs2, id_uses_rs2 : instruction waiting in ID
//   ex_valid, ex_branch, ex_mem_read      : EX-stage instruction qualifiers
//   ex_rd, ex_rs1, ex_rs2                 : EX-stage register fields
//   mem_valid, mem_reg_write, mem_rd      : EX/MEM producer
//   wb_valid, wb_reg_write, wb_rd         : MEM/WB producer
//   zero_flag                             : ALU zero for the EX instruction
//   pc_src, flush                         : branch taken in EX, squash IF/ID
//   stall                                 : load-use stall (already loses to flush)
//   fwd_a, fwd_b                          : EX operand source selects
module hazard_detect
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs2,
  input  logic                  ex_valid,
  input  logic                  ex_branch,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic                  mem_valid,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  wb_valid,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  zero_flag,
  output logic                  pc_src,
  output logic                  flush,
  output logic                  stall,
  output fwd_sel_e              fwd_a,
  output fwd_sel_e              fwd_b
);

  logic load_use;
  logic mem_fwd_ok;
  logic wb_fwd_ok;

  assign pc_src = ex_valid & ex_branch & zero_flag;
  assign flush  = pc_src;

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign load_use = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
                    ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

  // A taken branch squashes the ID instruction, so stalling it would only
  // waste a cycle on the wrong path.
  assign stall = load_use & ~pc_src;

  assign mem_fwd_ok = mem_valid & mem_reg_write & (mem_rd != '0);
  assign wb_fwd_ok  = wb_valid  & wb_reg_write  & (wb_rd  != '0);

  // EX/MEM holds the younger result, so it overrides MEM/WB for the same rd.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (mem_fwd_ok && (mem_rd == ex_rs1)) begin
      fwd_a = FWD_MEM;
    end else if (wb_fwd_ok && (wb_rd == ex_rs1)) begin
      fwd_a = FWD_WB;
    end
    if (mem_fwd_ok && (mem_rd == ex_rs2)) begin
      fwd_b = FWD_MEM;
    end else if (wb_fwd_ok && (wb_rd == ex_rs2)) begin
      fwd_b = FWD_WB;
    end
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline
// Carries the decoded control bundle from ID through the EX, MEM and WB
// pipeline registers, and drives the stall / flush / forwarding controls.
//   clk, rst                     : core clock, synchronous active-high reset
//   id_ctrl, id_valid            : bundle and valid from main_control
//   id_rs1, id_rs2, id_rd        : register fields of the ID instruction
//   id_uses_rs2                  : ID instruction reads rs2
//   zero_flag                    : ALU zero for the EX instruction
//   ex/mem/wb_ctrl, ex/mem/wb_rd : per-stage bundle and destination
//   fwd_a, fwd_b                 : 00 regfile, 10 EX/MEM, 01 MEM/WB
//   pc_write_en, if_id_write_en  : 0 holds PC / IF-ID (load-use stall)
//   if_id_flush, pc_src          : branch taken in EX
//   stall_cnt, flush_cnt         : saturating event counters
module ctrl_pipeline
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  ctrl_t                 id_ctrl,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_uses_rs2,
  input  logic                  zero_flag,
  output ctrl_t                 ex_ctrl,
  output ctrl_t                 mem_ctrl,
  output ctrl_t                 wb_ctrl,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  pc_write_en,
  output logic                  if_id_write_en,
  output logic                  if_id_flush,
  output logic                  pc_src,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  logic                  ex_valid;
  logic                  mem_valid;
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] ex_rs1;
  logic [REG_ADDR_W-1:0] ex_rs2;
  logic                  stall;
  logic                  flush;
  logic                  bubble;
  fwd_sel_e              fwd_a_sel;
  fwd_sel_e              fwd_b_sel;

  hazard_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hazard (
    .id_valid      (id_valid),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_uses_rs2   (id_uses_rs2),
    .ex_valid      (ex_valid),
    .ex_branch     (ex_ctrl.branch),
    .ex_mem_read   (ex_ctrl.mem_read),
    .ex_rd         (ex_rd),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .mem_valid     (mem_valid),
    .mem_reg_write (mem_ctrl.reg_write),
    .mem_rd        (mem_rd),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_ctrl.reg_write),
    .wb_rd         (wb_rd),
    .zero_flag     (zero_flag),
    .pc_src        (pc_src),
    .flush         (flush),
    .stall         (stall),
    .fwd_a         (fwd_a_sel),
    .fwd_b         (fwd_b_sel)
  );

  assign fwd_a          = fwd_a_sel;
  assign fwd_b          = fwd_b_sel;
  assign pc_write_en    = ~stall;
  assign if_id_write_en = ~stall;
  assign if_id_flush    = flush;

  // Anything that must not execute enters EX as an all-zero NOP bundle.
  assign bubble = stall | flush | ~id_valid;

  // Stage registers. Only ctrl and valid are bubbled; the register fields
  // travel unconditionally because a zero bundle never writes or forwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_ctrl   <= '0;
      ex_rd     <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      mem_valid <= 1'b0;
      mem_ctrl  <= '0;
      mem_rd    <= '0;
      wb_valid  <= 1'b0;
      wb_ctrl   <= '0;
      wb_rd     <= '0;
    end else begin
      ex_valid  <= ~bubble;
      ex_ctrl   <= bubble ? ctrl_t'('0) : id_ctrl;
      ex_rd     <= id_rd;
      ex_rs1    <= id_rs1;
      ex_rs2    <= id_rs2;
      mem_valid <= ex_valid;
      mem_ctrl  <= ex_ctrl;
      mem_rd    <= ex_rd;
      wb_valid  <= mem_valid;
      wb_ctrl   <= mem_ctrl;
      wb_rd     <= mem_rd;
    end
  end

  // Event counters stick at all-ones rather than wrapping back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb_ctrl_pipeline
// Directed bench for ctrl_pipeline. Every instruction expected to reach WB
// is queued when driven into ID and compared when it shows up in WB;
// stall, flush and forwarding outputs are compared against fixed values.
module tb_ctrl_pipeline;
  import ctrl_pkg::*;

  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 4;

  localparam ctrl_t C_R    = ctrl_t'(8'b10_000001);
  localparam ctrl_t C_LW   = ctrl_t'(8'b00_010111);
  localparam ctrl_t C_BEQ  = ctrl_t'(8'b01_100000);
  localparam ctrl_t C_LDBR = ctrl_t'(8'b01_110000);

  logic                  clk = 1'b0;
  logic                  rst;
  ctrl_t                 id_ctrl;
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_uses_rs2;
  logic                  zero_flag;
  ctrl_t                 ex_ctrl;
  ctrl_t                 mem_ctrl;
  ctrl_t                 wb_ctrl;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;
  logic                  pc_write_en;
  logic                  if_id_write_en;
  logic                  if_id_flush;
  logic                  pc_src;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  typedef struct packed {
    ctrl_t                 ctrl;
    logic [REG_ADDR_W-1:0] rd;
  } retire_t;

  retire_t expQ[$];
  int      errors = 0;
  int      checks = 0;
  int      expStall;

  ctrl_pipeline #(
    .REG_ADDR_W(REG_ADDR_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_ctrl       (id_ctrl),
    .id_valid      (id_valid),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rd         (id_rd),
    .id_uses_rs2   (id_uses_rs2),
    .zero_flag     (zero_flag),
    .ex_ctrl       (ex_ctrl),
    .mem_ctrl      (mem_ctrl),
    .wb_ctrl       (wb_ctrl),
    .ex_rd         (ex_rd),
    .mem_rd        (mem_rd),
    .wb_rd         (wb_rd),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
    .pc_write_en   (pc_write_en),
    .if_id_write_en(if_id_write_en),
    .if_id_flush   (if_id_flush),
    .pc_src        (pc_src),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input ctrl_t c, input logic v,
                               input logic [REG_ADDR_W-1:0] rs1,
                               input logic [REG_ADDR_W-1:0] rs2,
                               input logic [REG_ADDR_W-1:0] rd,
                               input logic u2, input logic zf);
    id_ctrl     = c;
    id_valid    = v;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rd       = rd;
    id_uses_rs2 = u2;
    zero_flag   = zf;
    #1;
  endtask

  // Drive a valid instruction into ID; queue it if it should reach WB.
  task automatic issue(input ctrl_t c, input logic [REG_ADDR_W-1:0] rs1,
                       input logic [REG_ADDR_W-1:0] rs2,
                       input logic [REG_ADDR_W-1:0] rd,
                       input logic u2, input logic accept);
    retire_t e;
    applyStimulus(c, 1'b1, rs1, rs2, rd, u2, 1'b0);
    if (accept) begin
      e.ctrl = c;
      e.rd   = rd;
      expQ.push_back(e);
    end
  endtask

  task automatic nop();
    applyStimulus(ctrl_t'(8'h00), 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  // One clock edge, then retire whatever arrived in WB against the queue.
  task automatic tick();
    retire_t e;
    @(posedge clk);
    #1;
    if (wb_ctrl != ctrl_t'(8'h00)) begin
      if (expQ.size() == 0) begin
        checkOutput("retire_unexpected", 32'(wb_ctrl), 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("retire_ctrl", 32'(wb_ctrl), 32'(e.ctrl));
        checkOutput("retire_rd", 32'(wb_rd), 32'(e.rd));
      end
    end
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  task automatic checkReset(input string p);
    checkOutput({p, "_ex_ctrl"}, 32'(ex_ctrl), 32'd0);
    checkOutput({p, "_mem_ctrl"}, 32'(mem_ctrl), 32'd0);
    checkOutput({p, "_wb_ctrl"}, 32'(wb_ctrl), 32'd0);
    checkOutput({p, "_ex_rd"}, 32'(ex_rd), 32'd0);
    checkOutput({p, "_mem_rd"}, 32'(mem_rd), 32'd0);
    checkOutput({p, "_wb_rd"}, 32'(wb_rd), 32'd0);
    checkOutput({p, "_pc_write_en"}, 32'(pc_write_en), 32'd1);
    checkOutput({p, "_if_id_write_en"}, 32'(if_id_write_en), 32'd1);
    checkOutput({p, "_if_id_flush"}, 32'(if_id_flush), 32'd0);
    checkOutput({p, "_pc_src"}, 32'(pc_src), 32'd0);
    checkOutput({p, "_fwd_a"}, 32'(fwd_a), 32'd0);
    checkOutput({p, "_fwd_b"}, 32'(fwd_b), 32'd0);
    checkOutput({p, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
    checkOutput({p, "_flush_cnt"}, 32'(flush_cnt), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held for two edges with a live R-type presented in ID.
    rst = 1'b1;
    applyStimulus(C_R, 1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
    tick();
    tick();
    checkReset("rst");
    rst = 1'b0;
    nop();
    tick();

    // Independent R-types flow through EX, MEM, WB on consecutive edges.
    issue(C_R, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
    tick();
    checkOutput("r_ex_ctrl", 32'(ex_ctrl), 32'(C_R));
    checkOutput("r_ex_rd", 32'(ex_rd), 32'd5);
    issue(C_R, 5'd3, 5'd4, 5'd6, 1'b1, 1'b1);
    checkOutput("r_no_stall", 32'(pc_write_en), 32'd1);
    tick();
    checkOutput("r_mem_ctrl", 32'(mem_ctrl), 32'(C_R));
    checkOutput("r_mem_rd", 32'(mem_rd), 32'd5);
    checkOutput("r_ex_rd2", 32'(ex_rd), 32'd6);
    checkOutput("r_fwd_a", 32'(fwd_a), 32'd0);
    checkOutput("r_fwd_b", 32'(fwd_b), 32'd0);
    nop();
    tick();
    checkOutput("r_wb_ctrl", 32'(wb_ctrl), 32'(C_R));
    checkOutput("r_wb_rd", 32'(wb_rd), 32'd5);
    tick();
    tick();
    checkOutput("r_stall_cnt", 32'(stall_cnt), 32'd0);

    // Load-use: one stall cycle, bubble, then MEM/WB forwarding.
    issue(C_LW, 5'd2, 5'd0, 5'd5, 1'b0, 1'b1);
    tick();
    issue(C_R, 5'd5, 5'd1, 5'd7, 1'b1, 1'b0);
    checkOutput("lu_pc_write_en", 32'(pc_write_en), 32'd0);
    checkOutput("lu_if_id_write_en", 32'(if_id_write_en), 32'd0);
    checkOutput("lu_pc_src", 32'(pc_src), 32'd0);
    checkOutput("lu_if_id_flush", 32'(if_id_flush), 32'd0);
    tick();
    checkOutput("lu_bubble", 32'(ex_ctrl), 32'd0);
    checkOutput("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    checkOutput("lu_load_in_mem", 32'(mem_ctrl), 32'(C_LW));
    issue(C_R, 5'd5, 5'd1, 5'd7, 1'b1, 1'b1);
    checkOutput("lu_release_pc", 32'(pc_write_en), 32'd1);
    checkOutput("lu_release_ifid", 32'(if_id_write_en), 32'd1);
    tick();
    checkOutput("lu_ex_ctrl", 32'(ex_ctrl), 32'(C_R));
    checkOutput("lu_fwd_a", 32'(fwd_a), 32'd1);
    checkOutput("lu_fwd_b", 32'(fwd_b), 32'd0);
    nop();
    tick();
    checkOutput("lu_single_stall", 32'(stall_cnt), 32'd1);
    drain();

    // Back-to-back dependence forwards from EX/MEM.
    issue(C_R, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
    tick();
    issue(C_R, 5'd5, 5'd5, 5'd6, 1'b1, 1'b1);
    tick();
    checkOutput("b2b_fwd_a", 32'(fwd_a), 32'd2);
    checkOutput("b2b_fwd_b", 32'(fwd_b), 32'd2);
    drain();

    // One NOP apart forwards from MEM/WB.
    issue(C_R, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
    tick();
    nop();
    tick();
    issue(C_R, 5'd5, 5'd5, 5'd6, 1'b1, 1'b1);
    tick();
    checkOutput("gap_fwd_a", 32'(fwd_a), 32'd1);
    checkOutput("gap_fwd_b", 32'(fwd_b), 32'd1);
    drain();

    // x0 as destination never forwards.
    issue(C_R, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1);
    tick();
    issue(C_R, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1);
    tick();
    checkOutput("x0_fwd_a", 32'(fwd_a), 32'd0);
    checkOutput("x0_fwd_b", 32'(fwd_b), 32'd0);
    drain();

    // Both stages write x5: the younger EX/MEM result wins.
    issue(C_R, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
    tick();
    issue(C_R, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1);
    tick();
    issue(C_R, 5'd5, 5'd5, 5'd6, 1'b1, 1'b1);
    tick();
    checkOutput("prio_fwd_a", 32'(fwd_a), 32'd2);
    checkOutput("prio_fwd_b", 32'(fwd_b), 32'd2);
    drain();

    // Taken branch flushes the ID instruction.
    issue(C_BEQ, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1);
    tick();
    applyStimulus(C_R, 1'b1, 5'd3, 5'd4, 5'd8, 1'b1, 1'b1);
    checkOutput("br_pc_src", 32'(pc_src), 32'd1);
    checkOutput("br_if_id_flush", 32'(if_id_flush), 32'd1);
    checkOutput("br_pc_write_en", 32'(pc_write_en), 32'd1);
    tick();
    nop();
    checkOutput("br_bubble", 32'(ex_ctrl), 32'd0);
    checkOutput("br_flush_cnt", 32'(flush_cnt), 32'd1);
    drain();

    // Not-taken branch lets the next instruction through.
    issue(C_BEQ, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1);
    tick();
    issue(C_R, 5'd3, 5'd4, 5'd8, 1'b1, 1'b1);
    checkOutput("nt_pc_src", 32'(pc_src), 32'd0);
    checkOutput("nt_if_id_flush", 32'(if_id_flush), 32'd0);
    tick();
    checkOutput("nt_ex_ctrl", 32'(ex_ctrl), 32'(C_R));
    checkOutput("nt_flush_cnt", 32'(flush_cnt), 32'd1);
    drain();

    // Branch-plus-load in EX with a dependent ID instruction: flush wins.
    issue(C_LDBR, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
    tick();
    applyStimulus(C_R, 1'b1, 5'd5, 5'd1, 5'd7, 1'b1, 1'b1);
    checkOutput("fs_pc_write_en", 32'(pc_write_en), 32'd1);
    checkOutput("fs_if_id_write_en", 32'(if_id_write_en), 32'd1);
    checkOutput("fs_if_id_flush", 32'(if_id_flush), 32'd1);
    tick();
    nop();
    checkOutput("fs_stall_cnt", 32'(stall_cnt), 32'd1);
    checkOutput("fs_flush_cnt", 32'(flush_cnt), 32'd2);
    checkOutput("fs_bubble", 32'(ex_ctrl), 32'd0);
    drain();

    // Repeated load-use pairs drive stall_cnt into saturation.
    expStall = 1;
    for (int i = 0; i < 16; i++) begin
      issue(C_LW, 5'd2, 5'd0, 5'd5, 1'b0, 1'b1);
      tick();
      issue(C_R, 5'd5, 5'd1, 5'd7, 1'b1, 1'b0);
      tick();
      expStall = (expStall < 15) ? expStall + 1 : 15;
      checkOutput("sat_stall_cnt", 32'(stall_cnt), 32'(expStall));
      issue(C_R, 5'd5, 5'd1, 5'd7, 1'b1, 1'b1);
      tick();
    end
    drain();
    checkOutput("sat_final", 32'(stall_cnt), 32'd15);
    checkOutput("sat_flush_cnt", 32'(flush_cnt), 32'd2);

    // Reset in the middle of a stall discards everything in flight.
    issue(C_LW, 5'd2, 5'd0, 5'd5, 1'b0, 1'b1);
    tick();
    issue(C_R, 5'd5, 5'd1, 5'd7, 1'b1, 1'b0);
    checkOutput("mid_stalling", 32'(pc_write_en), 32'd0);
    rst = 1'b1;
    tick();
    checkReset("rst_mid");
    expQ.delete();
    rst = 1'b0;
    nop();
    tick();

    // Pipeline resumes cleanly after the reset.
    issue(C_R, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1);
    tick();
    checkOutput("post_rst_ex_ctrl", 32'(ex_ctrl), 32'(C_R));
    drain();
    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
